// File: rtl/io_bus_pkg.sv
// Shared constants and types for the MCS IO bus bridge: bus width, bank map,
// bridge FSM encoding and the default error-response word.
package io_bus_pkg;

  localparam int unsigned DW = 32;

  localparam int unsigned CELLRAM = 0;
  localparam int unsigned MEMMODE = 1;
  localparam int unsigned LEDBANK = 2;
  localparam int unsigned PS2BANK = 3;
  localparam int unsigned VGABANK = 4;
  localparam int unsigned GRAPH   = 5;
  localparam int unsigned CAMPIC  = 6;
  localparam int unsigned CAMCTRL = 7;

  typedef enum logic [1:0] {
    StIdle,
    StStrb,
    StWait,
    StAck
  } io_state_e;

  localparam logic [DW-1:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  // Bank field width, never narrower than one bit.
  function automatic int unsigned bank_width(input int unsigned nbank);
    return (nbank > 1) ? $clog2(nbank) : 1;
  endfunction

endpackage

// File: rtl/io_wait_timer.sv
// Saturating wait-state counter; expire_o flags the last permitted WAIT cycle.
module io_wait_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] CntLast = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] CntMax  = TW'(TIMEOUT);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == CntLast);

endmodule

// File: rtl/io_bank_bridge.sv
// MCS IO bus to per-bank strobe bridge with wait states, timeout error response
// and sticky error reporting.
module io_bank_bridge
  import io_bus_pkg::*;
#(
  parameter int unsigned      NBANK     = 8,
  parameter int unsigned      BANK_LSB  = 29,
  parameter logic [NBANK-1:0] WAIT_MASK = '0,
  parameter int unsigned      TIMEOUT   = 255,
  parameter logic [DW-1:0]    ERR_DATA  = ERR_DATA_DEFAULT
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                IO_Addr_Strobe,
  input  logic                IO_Read_Strobe,
  input  logic                IO_Write_Strobe,
  input  logic [31:0]         IO_Address,
  output logic [DW-1:0]       IO_Read_Data,
  output logic                IO_Ready,
  output logic [NBANK-1:0]    WR,
  output logic [NBANK-1:0]    RD,
  input  logic [NBANK*DW-1:0] RDATA,
  input  logic [NBANK-1:0]    BANK_RDY,
  input  logic                ERR_CLR,
  output logic                BUS_ERR,
  output logic [3:0]          ERR_BANK,
  output logic                ERR_OVR
);

  localparam int unsigned BW = bank_width(NBANK);
  localparam logic [BW:0] NBankW = (BW + 1)'(NBANK);

  io_state_e     state_q, state_d;
  logic [BW-1:0] bank_q, bank_d;
  logic          write_q, write_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          bus_err_q, bus_err_d;
  logic [3:0]    err_bank_q, err_bank_d;
  logic          err_ovr_q, err_ovr_d;

  logic             strobe, addr_oor, err_set, ovr_set, tmr_clr, tmr_en, tmr_expire;
  logic [BW-1:0]    addr_bank, err_bank_new;
  logic [NBANK-1:0] bank_oh;
  logic [DW-1:0]    sel_rdata;
  logic             sel_rdy, sel_wait;
  logic             unused_addr;

  assign strobe      = IO_Addr_Strobe & (IO_Read_Strobe | IO_Write_Strobe);
  assign addr_bank   = IO_Address[BANK_LSB +: BW];
  assign addr_oor    = ({1'b0, addr_bank} >= NBankW);
  assign unused_addr = ^IO_Address;

  always_comb begin
    bank_oh   = '0;
    sel_rdata = '0;
    sel_rdy   = 1'b0;
    sel_wait  = 1'b0;
    for (int b = 0; b < int'(NBANK); b++) begin
      if (bank_q == BW'(b)) begin
        bank_oh[b] = 1'b1;
        sel_rdata  = RDATA[b*DW +: DW];
        sel_rdy    = BANK_RDY[b];
        sel_wait   = WAIT_MASK[b];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    bank_d       = bank_q;
    write_d      = write_q;
    rdata_d      = '0;
    err_set      = 1'b0;
    ovr_set      = 1'b0;
    tmr_clr      = 1'b0;
    tmr_en       = 1'b0;
    err_bank_new = bank_q;
    unique case (state_q)
      StIdle: begin
        if (strobe) begin
          bank_d  = addr_bank;
          write_d = IO_Write_Strobe;
          ovr_set = IO_Read_Strobe & IO_Write_Strobe;
          if (addr_oor) begin
            state_d      = StAck;
            rdata_d      = ERR_DATA;
            err_set      = 1'b1;
            err_bank_new = addr_bank;
          end else begin
            state_d = StStrb;
          end
        end
      end
      StStrb: begin
        if (sel_wait) begin
          state_d = StWait;
          tmr_clr = 1'b1;
        end else begin
          state_d = StAck;
          rdata_d = write_q ? '0 : sel_rdata;
        end
      end
      StWait: begin
        // Ready beats a coincident timeout.
        if (sel_rdy) begin
          state_d = StAck;
          rdata_d = write_q ? '0 : sel_rdata;
        end else if (tmr_expire) begin
          state_d = StAck;
          rdata_d = ERR_DATA;
          err_set = 1'b1;
        end else begin
          tmr_en = 1'b1;
        end
      end
      StAck: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (strobe && (state_q != StIdle)) begin
      ovr_set = 1'b1;
    end
  end

  // A new error on the same edge as ERR_CLR survives the clear.
  always_comb begin
    bus_err_d  = bus_err_q;
    err_bank_d = err_bank_q;
    err_ovr_d  = err_ovr_q;
    if (ERR_CLR) begin
      bus_err_d  = 1'b0;
      err_bank_d = '0;
      err_ovr_d  = 1'b0;
    end
    if (err_set) begin
      bus_err_d = 1'b1;
      if (!bus_err_q || ERR_CLR) begin
        err_bank_d = 4'(err_bank_new);
      end
    end
    if (ovr_set) begin
      err_ovr_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      bank_q     <= '0;
      write_q    <= 1'b0;
      rdata_q    <= '0;
      bus_err_q  <= 1'b0;
      err_bank_q <= '0;
      err_ovr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bank_q     <= bank_d;
      write_q    <= write_d;
      rdata_q    <= rdata_d;
      bus_err_q  <= bus_err_d;
      err_bank_q <= err_bank_d;
      err_ovr_q  <= err_ovr_d;
    end
  end

  io_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clk_i   (CLK),
    .rst_i   (RST),
    .clr_i   (tmr_clr),
    .en_i    (tmr_en),
    .expire_o(tmr_expire)
  );

  assign IO_Ready     = (state_q == StAck);
  assign IO_Read_Data = rdata_q;
  assign WR           = ((state_q == StStrb) && write_q)  ? bank_oh : '0;
  assign RD           = ((state_q == StStrb) && !write_q) ? bank_oh : '0;
  assign BUS_ERR      = bus_err_q;
  assign ERR_BANK     = err_bank_q;
  assign ERR_OVR      = err_ovr_q;

endmodule

// File: tb/tb_io_bank_bridge.sv
// Scoreboard bench: two bridge instances (8 banks with a wait bank, 6 banks for range errors).
module tb_io_bank_bridge;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } resp_t;

  typedef struct {
    int         cyc;
    logic [7:0] wr;
    logic [7:0] rd;
  } stb_t;

  logic CLK = 1'b0;
  always #10 CLK = ~CLK;

  logic RST, ERR_CLR;
  int   cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic         a_as, a_rs, a_ws;
  logic [31:0]  a_addr, a_rdata_o;
  logic         a_ready, a_bus_err, a_err_ovr;
  logic [7:0]   a_wr, a_rd, a_bank_rdy;
  logic [255:0] a_rdata_in;
  logic [3:0]   a_err_bank;

  logic         b_as, b_rs, b_ws;
  logic [31:0]  b_addr, b_rdata_o;
  logic         b_ready, b_bus_err, b_err_ovr;
  logic [5:0]   b_wr, b_rd, b_bank_rdy;
  logic [191:0] b_rdata_in;
  logic [3:0]   b_err_bank;

  resp_t qa[$];
  resp_t qb[$];
  stb_t  qs[$];
  resp_t ea, eb;
  stb_t  es;
  int    n_asserts = 0;
  int    n_fail = 0;
  bit    started = 1'b0;

  io_bank_bridge #(
    .NBANK(8), .BANK_LSB(29), .WAIT_MASK(8'h01), .TIMEOUT(16)
  ) u_dut_a (
    .CLK(CLK), .RST(RST), .IO_Addr_Strobe(a_as), .IO_Read_Strobe(a_rs),
    .IO_Write_Strobe(a_ws), .IO_Address(a_addr), .IO_Read_Data(a_rdata_o),
    .IO_Ready(a_ready), .WR(a_wr), .RD(a_rd), .RDATA(a_rdata_in), .BANK_RDY(a_bank_rdy),
    .ERR_CLR(ERR_CLR), .BUS_ERR(a_bus_err), .ERR_BANK(a_err_bank), .ERR_OVR(a_err_ovr)
  );

  io_bank_bridge #(
    .NBANK(6)
  ) u_dut_b (
    .CLK(CLK), .RST(RST), .IO_Addr_Strobe(b_as), .IO_Read_Strobe(b_rs),
    .IO_Write_Strobe(b_ws), .IO_Address(b_addr), .IO_Read_Data(b_rdata_o),
    .IO_Ready(b_ready), .WR(b_wr), .RD(b_rd), .RDATA(b_rdata_in), .BANK_RDY(b_bank_rdy),
    .ERR_CLR(ERR_CLR), .BUS_ERR(b_bus_err), .ERR_BANK(b_err_bank), .ERR_OVR(b_err_ovr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_asserts++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one bus cycle; expectations are queued for the monitors.
  task automatic issue(input bit on_b, input logic [31:0] addr, input bit rd, input bit wr,
                       input int hold, input bit exp_ack, input int lat,
                       input logic [31:0] exp_data, input logic [7:0] exp_wr,
                       input logic [7:0] exp_rd);
    @(posedge CLK); #1;
    if (exp_ack) begin
      if (on_b) qb.push_back('{cyc + lat, exp_data});
      else      qa.push_back('{cyc + lat, exp_data});
    end
    if (!on_b && ((exp_wr | exp_rd) != 8'h00)) qs.push_back('{cyc + 1, exp_wr, exp_rd});
    if (on_b) begin
      b_as = 1'b1; b_rs = rd; b_ws = wr; b_addr = addr;
    end else begin
      a_as = 1'b1; a_rs = rd; a_ws = wr; a_addr = addr;
    end
    repeat (hold) @(posedge CLK);
    #1;
    a_as = 1'b0; a_rs = 1'b0; a_ws = 1'b0;
    b_as = 1'b0; b_rs = 1'b0; b_ws = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while ((qa.size() != 0 || qb.size() != 0 || qs.size() != 0) && t < 60) begin
      @(posedge CLK);
      t++;
    end
    if (t >= 60) begin
      n_asserts++;
      n_fail++;
      $display("FAIL response_timeout: %0d/%0d/%0d items pending, required 0",
               qa.size(), qb.size(), qs.size());
      qa.delete(); qb.delete(); qs.delete();
    end
    @(posedge CLK); #1;
  endtask

  task automatic pulse_clr();
    @(posedge CLK); #1 ERR_CLR = 1'b1;
    @(posedge CLK); #1 ERR_CLR = 1'b0;
  endtask

  always @(negedge CLK) begin
    if (started) begin
      if (a_ready) begin
        if (qa.size() == 0) begin
          check("a_unexpected_ready", {31'b0, a_ready}, 32'h0);
        end else begin
          ea = qa.pop_front();
          check("a_ack_cycle", 32'(cyc), 32'(ea.cyc));
          check("a_ack_data", a_rdata_o, ea.data);
        end
      end else if (a_rdata_o != 32'h0) begin
        check("a_data_outside_ack", a_rdata_o, 32'h0);
      end
      if ((a_wr | a_rd) != 8'h00) begin
        if (qs.size() == 0) begin
          check("a_unexpected_strobe", {16'b0, a_wr, a_rd}, 32'h0);
        end else begin
          es = qs.pop_front();
          check("a_strobe_cycle", 32'(cyc), 32'(es.cyc));
          check("a_wr", {24'b0, a_wr}, {24'b0, es.wr});
          check("a_rd", {24'b0, a_rd}, {24'b0, es.rd});
        end
      end
      if (b_ready) begin
        if (qb.size() == 0) begin
          check("b_unexpected_ready", {31'b0, b_ready}, 32'h0);
        end else begin
          eb = qb.pop_front();
          check("b_ack_cycle", 32'(cyc), 32'(eb.cyc));
          check("b_ack_data", b_rdata_o, eb.data);
        end
      end
      if ((b_wr | b_rd) != 6'h00) check("b_unexpected_strobe", {20'b0, b_wr, b_rd}, 32'h0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; ERR_CLR = 1'b0;
    a_as = 1'b0; a_rs = 1'b0; a_ws = 1'b0; a_addr = '0; a_bank_rdy = '0;
    b_as = 1'b0; b_rs = 1'b0; b_ws = 1'b0; b_addr = '0; b_bank_rdy = '0;
    a_rdata_in = '0;
    a_rdata_in[0*32 +: 32] = 32'hCAFE_0000;
    a_rdata_in[2*32 +: 32] = 32'h1234_5678;
    a_rdata_in[4*32 +: 32] = 32'h4444_4444;
    b_rdata_in = {6{32'h5555_AAAA}};
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    started = 1'b1;
    @(negedge CLK);
    check("rst_ready", {31'b0, a_ready}, 32'h0);
    check("rst_wr_rd", {16'b0, a_wr, a_rd}, 32'h0);
    check("rst_rdata", a_rdata_o, 32'h0);
    check("rst_err", {26'b0, a_bus_err, a_err_ovr, a_err_bank}, 32'h0);

    // Write bank 4, then read bank 2.
    issue(1'b0, 32'h8000_0010, 1'b0, 1'b1, 1, 1'b1, 2, 32'h0, 8'h10, 8'h00);
    wait_done();
    issue(1'b0, 32'h4000_0000, 1'b1, 1'b0, 1, 1'b1, 2, 32'h1234_5678, 8'h00, 8'h04);
    wait_done();

    // Wait bank 0 with a late ready.
    issue(1'b0, 32'h0000_0000, 1'b1, 1'b0, 1, 1'b1, 8, 32'hCAFE_0000, 8'h00, 8'h01);
    repeat (6) @(posedge CLK);
    #1 a_bank_rdy = 8'h01;
    @(posedge CLK); #1 a_bank_rdy = 8'h00;
    wait_done();
    check("wait_bus_err", {31'b0, a_bus_err}, 32'h0);

    // Wait bank 0 never ready: timeout.
    issue(1'b0, 32'h0000_0000, 1'b1, 1'b0, 1, 1'b1, 18, 32'hDEAD_BEEF, 8'h00, 8'h01);
    wait_done();
    check("tmo_bus_err", {31'b0, a_bus_err}, 32'h1);
    check("tmo_err_bank", {28'b0, a_err_bank}, 32'h0);
    pulse_clr();
    @(negedge CLK);
    check("clr_bus_err", {31'b0, a_bus_err}, 32'h0);

    // Read+write together acts as a write and flags overlap.
    issue(1'b0, 32'h8000_0000, 1'b1, 1'b1, 1, 1'b1, 2, 32'h0, 8'h10, 8'h00);
    wait_done();
    check("rw_err_ovr", {31'b0, a_err_ovr}, 32'h1);
    pulse_clr();
    @(negedge CLK);
    check("clr_err_ovr", {31'b0, a_err_ovr}, 32'h0);

    // Strobe held into the busy cycle is ignored but flagged.
    issue(1'b0, 32'h4000_0000, 1'b1, 1'b0, 2, 1'b1, 2, 32'h1234_5678, 8'h00, 8'h04);
    wait_done();
    check("busy_err_ovr", {31'b0, a_err_ovr}, 32'h1);
    check("busy_bus_err", {31'b0, a_bus_err}, 32'h0);
    pulse_clr();

    // Reset while in WAIT aborts without a response.
    issue(1'b0, 32'h0000_0000, 1'b1, 1'b0, 1, 1'b0, 0, 32'h0, 8'h00, 8'h01);
    repeat (3) @(posedge CLK);
    #1 RST = 1'b1;
    @(posedge CLK); #1 RST = 1'b0;
    @(negedge CLK);
    check("abort_ready", {31'b0, a_ready}, 32'h0);
    check("abort_wr_rd", {16'b0, a_wr, a_rd}, 32'h0);
    check("abort_rdata", a_rdata_o, 32'h0);
    check("abort_err", {26'b0, a_bus_err, a_err_ovr, a_err_bank}, 32'h0);
    repeat (20) @(posedge CLK);
    issue(1'b0, 32'h4000_0000, 1'b1, 1'b0, 1, 1'b1, 2, 32'h1234_5678, 8'h00, 8'h04);
    wait_done();

    // Out-of-range banks on the 6-bank bridge; first error bank is kept.
    issue(1'b1, 32'hE000_0000, 1'b1, 1'b0, 1, 1'b1, 1, 32'hDEAD_BEEF, 8'h00, 8'h00);
    wait_done();
    check("oor_bus_err", {31'b0, b_bus_err}, 32'h1);
    check("oor_err_bank", {28'b0, b_err_bank}, 32'h7);
    issue(1'b1, 32'hC000_0000, 1'b1, 1'b0, 1, 1'b1, 1, 32'hDEAD_BEEF, 8'h00, 8'h00);
    wait_done();
    check("oor_err_bank_kept", {28'b0, b_err_bank}, 32'h7);
    check("oor_err_ovr", {31'b0, b_err_ovr}, 32'h0);

    check("queues_empty", 32'(qa.size() + qb.size() + qs.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
